// File: rtl/sum_sequencer_if.sv
// Handshake/result bundle between the summation sequencer and its driver.
// Master drives tick/start/data; slave (the sequencer) returns status and BCD result.
interface sum_sequencer_if;
  logic        tick;
  logic        start;
  logic [5:0]  data;
  logic        busy;
  logic        done;
  logic [1:0]  status;
  logic [10:0] sum;
  logic [3:0]  bcd_thousands;
  logic [3:0]  bcd_hundreds;
  logic [3:0]  bcd_tens;
  logic [3:0]  bcd_units;

  modport master (
    output tick, start, data,
    input  busy, done, status, sum,
    input  bcd_thousands, bcd_hundreds, bcd_tens, bcd_units
  );

  modport slave (
    input  tick, start, data,
    output busy, done, status, sum,
    output bcd_thousands, bcd_hundreds, bcd_tens, bcd_units
  );
endinterface

// File: rtl/sum_sequencer.sv
// Computes 1+..+N iteratively, then double-dabbles it to 4 BCD digits; N+11 ticks (11 for N=0).
// No backpressure: a start edge is only honoured in IDLE/DONE, all stepping is gated by tick.
module sum_sequencer (
  input  logic              clk,
  input  logic              rst,
  sum_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t      state;
  logic        start_q;
  logic        start_armed;
  logic [5:0]  n;
  logic [10:0] acc;
  logic [6:0]  idx;
  logic [10:0] bin;
  logic [15:0] scratch;
  logic [3:0]  bitcnt;
  logic [10:0] sum_r;
  logic [15:0] bcd_r;
  logic        busy_r;
  logic        valid_r;
  logic        done_r;

  logic        start_edge;
  logic [15:0] adj;
  logic [15:0] scratch_nxt;

  // A start held through reset deassertion must fall before it can count as an edge.
  assign start_edge = bus.tick & bus.start & ~start_q & start_armed;

  always_comb begin
    adj = scratch;
    for (int d = 0; d < 4; d++) begin
      if (scratch[4*d +: 4] >= 4'd5) begin
        adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
      end
    end
    scratch_nxt = {adj[14:0], bin[10]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      start_q     <= 1'b0;
      start_armed <= 1'b0;
      n           <= '0;
      acc         <= '0;
      idx         <= '0;
      bin         <= '0;
      scratch     <= '0;
      bitcnt      <= '0;
      sum_r       <= '0;
      bcd_r       <= '0;
      busy_r      <= 1'b0;
      valid_r     <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (bus.tick) begin
        start_q <= bus.start;
        if (!bus.start) begin
          start_armed <= 1'b1;
        end
        case (state)
          IDLE, DONE: begin
            if (start_edge) begin
              n       <= bus.data;
              acc     <= '0;
              idx     <= 7'd1;
              busy_r  <= 1'b1;
              valid_r <= 1'b0;
              if (bus.data == 6'd0) begin
                bin     <= '0;
                scratch <= '0;
                bitcnt  <= '0;
                state   <= CONVERT;
              end else begin
                state   <= ACCUM;
              end
            end
          end
          ACCUM: begin
            // acc ends up holding the final sum, which is what gets published on DONE
            acc <= acc + {4'd0, idx};
            idx <= idx + 7'd1;
            if (idx == {1'b0, n}) begin
              bin     <= acc + {4'd0, idx};
              scratch <= '0;
              bitcnt  <= '0;
              state   <= CONVERT;
            end
          end
          CONVERT: begin
            scratch <= scratch_nxt;
            bin     <= {bin[9:0], 1'b0};
            bitcnt  <= bitcnt + 4'd1;
            if (bitcnt == 4'd10) begin
              sum_r   <= acc;
              bcd_r   <= scratch_nxt;
              busy_r  <= 1'b0;
              valid_r <= 1'b1;
              done_r  <= 1'b1;
              state   <= DONE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.busy          = busy_r;
  assign bus.done          = done_r;
  assign bus.status        = {valid_r, busy_r};
  assign bus.sum           = sum_r;
  assign bus.bcd_thousands = bcd_r[15:12];
  assign bus.bcd_hundreds  = bcd_r[11:8];
  assign bus.bcd_tens      = bcd_r[7:4];
  assign bus.bcd_units     = bcd_r[3:0];

endmodule

// File: doc/sum_sequencer.md
# sum_sequencer

Sequencing controller for the summation datapath: on a start request it latches a 6-bit operand N, runs an iterative accumulation of 1 + 2 + … + N (one addition per step), then converts the 11-bit result to four BCD digits with a sequential shift-add-3 pass. All stepping is gated by a one-clock-wide step enable from the clock-divider, so the whole block lives in the single fast clock domain. The outputs feed the existing 7-segment decoders and status LEDs.

## Interface
Single clock; reset is synchronous, active-high.
- No parameters; widths are fixed: N 6 bits, sum 11 bits (max 2016), 4 BCD digits.
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- tick  in  1  step enable, one clk wide; tie to 1 for full-rate operation
- start  in  1  start request; level input, rising edge detected on tick cycles
- data  in  6  operand N, captured at the accepted start edge
- busy  out  1  high in ACCUM or CONVERT
- done  out  1  one-clk pulse on entry to DONE
- status  out  2  [0] = busy, [1] = result valid (state DONE)
- sum  out  11  last completed result
- bcd_thousands, bcd_hundreds, bcd_tens, bcd_units  out  4 each  BCD digits of sum

## Operation
- States: IDLE, ACCUM, CONVERT, DONE. State changes occur only on clk edges where tick = 1, except rst.
- Start edge: start_q <= start on every tick cycle. Accepted edge = tick & start & ~start_q, honoured only in IDLE or DONE. It is ignored in ACCUM and CONVERT, but start_q still updates, so a held start does not retrigger later.
- Accepted edge:
  - n <= data, acc <= 0, idx <= 1.
  - If data = 0: load the converter with 0 and go to CONVERT.
  - Otherwise go to ACCUM.
- ACCUM (per tick):
  - acc <= acc + idx, idx <= idx + 1.
  - When idx = n: load the converter with acc + idx, clear BCD scratch and bit count, go to CONVERT.
- CONVERT (per tick): one double-dabble step.
  - Each 4-bit scratch digit ≥ 5 gets +3.
  - Then shift {scratch, bin} left by 1; bitcnt <= bitcnt + 1.
  - After the 11th step (bitcnt = 10): sum <= final binary value, BCD outputs <= final digits, go to DONE, assert done for one clk.
- DONE: hold results; an accepted start edge restarts exactly as from IDLE.
- Width rules:
  - acc is 11 bits; no overflow is possible (max 63·64/2 = 2016).
  - idx is 7 bits internally.
  - Scratch is 16 bits; bcd_thousands ≤ 2.
- sum and the BCD outputs change only on DONE entry. They hold the previous result throughout a new computation.
- n is latched, so changes on data while busy have no effect.

## Timing
- Reset values: state IDLE, busy 0, done 0, status 2'b00, sum 0, all BCD digits 0, start_q 0, acc/idx/n 0.
- Count ticks from the accepted-start tick T0.
  - N ≥ 1: ACCUM on ticks T1..TN; CONVERT on TN+1..TN+11; DONE, done pulse and new outputs visible the clk after tick TN+11.
  - N = 0: CONVERT on T1..T11; DONE after T11.
  - Latency in ticks is N + 11 for N ≥ 1, and 11 for N = 0.
- done is high exactly one clk cycle, not one tick, regardless of tick rate.
- With tick = 0 the FSM, acc, idx, converter and start_q all freeze. busy and status stay stable.
- rst asserted in any state, including mid-ACCUM/CONVERT: next clk returns all reset values. A start held high across reset deassertion is not an edge; start must drop and rise again.
- start edge on the same tick as the DONE transition: the state is still CONVERT, so the edge is ignored.

## Test plan
- tick = 1, pulse start with data = 10 → busy rises the clk after the start edge; done pulses 21 clks after the start tick; sum = 55; digits 0/0/5/5; status = 2'b10 after.
- data = 63 → sum = 2016, digits 2/0/1/6, done 74 clks after the start tick; data = 0 → sum = 0, done 11 clks after the start tick.
- tick pulsed every 4 clks, data = 3 → identical result 6 with latency 14 ticks (56 clks); done is 1 clk wide; state frozen between ticks.
- Second start edge and data change to 5 mid-ACCUM with data = 20 → ignored, sum = 210. Start held high through DONE → no restart. Start from DONE with data = 4 → old sum 210 held until the new done, then 10.
- rst during CONVERT of data = 50 → next clk: busy 0, sum 0, digits 0, status 0. Then start with data = 2 → sum = 3.
- Sweep data 0..63 → sum = N(N+1)/2 and BCD digits match a decimal reference model for every N.
